timer_src_mux: RTL
==================

TIMER_SRC_MUX -- requirements
Module: timer_src_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning bits per data channel (one BCD timer digit).
REQ-002 SHALL have parameter CHANNELS, default 4, meaning number of input sources (range 2..16).
REQ-003 SHALL have derived parameter SEL_W, default $clog2(CHANNELS), meaning width of channel index.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning synchronous active-low reset.
REQ-006 SHALL have port mode, input, 1, meaning 0 = manual select, 1 = round-robin scan.
REQ-007 SHALL have port sel, input, SEL_W, meaning the manual-mode channel index.
REQ-008 SHALL have port in_data, input, CHANNELS*WIDTH, meaning packed inputs; channel i at bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port in_valid, input, CHANNELS, meaning per-channel data-valid.
REQ-010 SHALL have port in_ready, output, CHANNELS, meaning per-channel accept, at most one bit high.
REQ-011 SHALL have port out_data, output, WIDTH, meaning registered selected data.
REQ-012 SHALL have port out_chan, output, SEL_W, meaning source index of out_data.
REQ-013 SHALL have port out_valid, output, 1, meaning out_data/out_chan hold a word.
REQ-014 SHALL have port out_ready, input, 1, meaning consumer accepts the word.

Function
REQ-015 SHALL hold a one-entry output register with states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 SHALL compute can_load = !out_valid || out_ready, combinationally.
REQ-017 SHALL, in manual mode, grant channel sel when in_valid[sel]; sel >= CHANNELS SHALL grant nothing.
REQ-018 SHALL, in round-robin mode, grant the first valid channel at or after pointer ptr, wrapping CHANNELS-1 -> 0.
REQ-019 SHALL drive in_ready[g] = can_load for the granted channel g only; all other in_ready bits 0.
REQ-020 SHALL, on a transfer (in_valid[g] && in_ready[g]), load out_data, out_chan = g and set out_valid next cycle (latency 1).
REQ-021 SHALL, after a round-robin transfer from channel g, set ptr = (g+1) mod CHANNELS; manual transfers SHALL NOT move ptr.
REQ-022 SHALL clear out_valid on out_ready && out_valid when no new transfer occurs the same cycle.
REQ-023 SHALL permit simultaneous drain and load in one cycle (one word per cycle sustained).
REQ-024 SHALL keep out_data, out_chan stable while out_valid && !out_ready, regardless of mode, sel or in_* changes.
REQ-025 SHALL apply mode/sel changes at the next arbitration only; a held word SHALL be unaffected.
REQ-026 SHALL, when no channel is valid, leave ptr unchanged and load nothing.

Reset
REQ-027 SHALL, while rst_n=0 at a clk edge, set out_valid=0, out_data=0, out_chan=0, ptr=0.
REQ-028 SHALL drive in_ready all-zero during reset; a word held mid-stall SHALL be discarded.
REQ-029 SHALL accept transfers on the first edge after rst_n returns high.

Structure
REQ-030 SHALL place mode encodings (MODE_MANUAL=0, MODE_RR=1) and default WIDTH/CHANNELS constants in package timer_mux_pkg.
REQ-031 SHALL implement round-robin grant search in one sub-module rr_arbiter (inputs req, ptr; output one-hot grant).
REQ-032 SHALL contain no latches; all state in the single clk domain.

Verification
REQ-033 SHALL check reset: rst_n=0 two cycles with all in_valid=1 -> out_valid=0, out_data=0, in_ready=0.
REQ-034 SHALL check manual: mode=0, sel=2, in_data ch2=4'h7, in_valid=4'b0100, out_ready=1 -> next cycle out_data=7, out_chan=2, out_valid=1.
REQ-035 SHALL check round-robin: mode=1, all valid, data ch i = i+1, out_ready=1 -> out_chan sequence 0,1,2,3,0, one per cycle.
REQ-036 SHALL check stall: FULL with out_data=5, out_ready=0 for 3 cycles while inputs change -> out_data stays 5, in_ready=0.
REQ-037 SHALL check boundary: CHANNELS=3, mode=0, sel=3 -> in_ready=0, out_valid stays 0; ptr=2 with only ch0 valid -> grant ch0, ptr becomes 1.
REQ-038 SHALL check reset mid-stall: FULL, rst_n=0 one cycle -> out_valid=0 next cycle, held word lost.

Source files
------------

// File: rtl/timer_mux_pkg.sv
// Shared constants and types for the timer digit source multiplexer.
package timer_mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    localparam int DEF_WIDTH    = 4;
    localparam int DEF_CHANNELS = 4;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant search: first requester at or after ptr, wrapping to 0.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    always_comb begin
        logic found;
        int   idx;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_src_mux.sv
// Selects one timer digit source (manual index or round-robin scan) into a
// one-entry registered output slot with valid/ready handshakes.
module timer_src_mux
    import timer_mux_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    out_state_e       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0] chan_q, chan_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic [CHANNELS-1:0] rr_grant;
    logic [CHANNELS-1:0] man_grant;
    logic [CHANNELS-1:0] grant;
    logic [SEL_W-1:0]    g_idx;
    logic [WIDTH-1:0]    g_data;
    logic                can_load;
    logic                xfer;

    rr_arbiter #(
        .N     (CHANNELS),
        .PTR_W (SEL_W)
    ) u_rr_arbiter (
        .req   (in_valid),
        .ptr   (ptr_q),
        .grant (rr_grant)
    );

    // An out-of-range sel matches no loop index, so it grants nothing.
    always_comb begin
        man_grant = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel == SEL_W'(i)) man_grant[i] = in_valid[i];
        end
    end

    assign grant    = (mode == MODE_RR) ? rr_grant : man_grant;
    assign can_load = (state_q == ST_EMPTY) || out_ready;
    assign in_ready = rst_n ? (grant & {CHANNELS{can_load}}) : '0;
    assign xfer     = |(in_valid & in_ready);

    always_comb begin
        g_idx  = '0;
        g_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant[i]) begin
                g_idx  = SEL_W'(i);
                g_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        chan_d  = chan_q;
        ptr_d   = ptr_q;
        if (xfer) begin
            state_d = ST_FULL;
            data_d  = g_data;
            chan_d  = g_idx;
            if (mode == MODE_RR) begin
                ptr_d = (g_idx == SEL_W'(CHANNELS - 1)) ? '0 : g_idx + SEL_W'(1);
            end
        end else if (out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            chan_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = data_q;
    assign out_chan  = chan_q;

endmodule
